// File: rtl/seven_seg_scan_driver_if.sv
// Bus between the CPU output-port register and the 7-segment scan driver.
// The master drives d/load; the slave drives the display pins and frame_done.
interface seven_seg_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic [31:0]       d;
  logic              load;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              dp;
  logic              frame_done;

  modport master (
    output d, load,
    input  seg, an, dp, frame_done
  );

  modport slave (
    input  d, load,
    output seg, an, dp, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver with a tear-free display copy.
// Optional macro SEVEN_SEG_BLANK_LEADING_ZEROS_EN blanks leading zero digits.
module seven_seg_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input logic                    clk,
  input logic                    clr,
  seven_seg_scan_driver_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PMAX    = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]     DMAX    = DW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW != 0}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW != 0}};

  logic [PW-1:0]     presc;
  logic [DW-1:0]     digit;
  logic [31:0]       pending;
  logic              flag;
  logic [31:0]       display;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] an_q;

  logic              presc_wrap;
  logic              boundary;
  logic [3:0]        nibble;
  logic [6:0]        seg_on;
  logic [DIGITS-1:0] an_on;
  logic              blank;

  assign presc_wrap = (presc == PMAX);
  assign boundary   = presc_wrap && (digit == DMAX);
  assign nibble     = 4'(display >> {digit, 2'b00});
  assign an_on      = DIGITS'(1) << digit;

  // Active-high gfedcba decode of the nibble currently being scanned.
  always_comb begin
    seg_on = 7'h00;
    case (nibble)
      4'h0: seg_on = 7'h3F;
      4'h1: seg_on = 7'h06;
      4'h2: seg_on = 7'h5B;
      4'h3: seg_on = 7'h4F;
      4'h4: seg_on = 7'h66;
      4'h5: seg_on = 7'h6D;
      4'h6: seg_on = 7'h7D;
      4'h7: seg_on = 7'h07;
      4'h8: seg_on = 7'h7F;
      4'h9: seg_on = 7'h6F;
      4'hA: seg_on = 7'h77;
      4'hB: seg_on = 7'h7C;
      4'hC: seg_on = 7'h39;
      4'hD: seg_on = 7'h5E;
      4'hE: seg_on = 7'h79;
      4'hF: seg_on = 7'h71;
      default: seg_on = 7'h00;
    endcase
  end

`ifdef SEVEN_SEG_BLANK_LEADING_ZEROS_EN
  logic [DIGITS-1:0] lead_zero;
  logic              lz;

  // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    lead_zero = '0;
    lz        = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz           = lz && (display[4*i +: 4] == 4'h0);
      lead_zero[i] = lz;
    end
    lead_zero[0] = 1'b0;
  end

  assign blank = |(lead_zero & an_on);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      presc   <= '0;
      digit   <= '0;
      pending <= '0;
      flag    <= 1'b0;
      display <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      presc <= presc_wrap ? '0 : presc + 1'b1;
      if (presc_wrap) begin
        digit <= (digit == DMAX) ? '0 : digit + 1'b1;
      end

      // A load landing on the boundary bypasses pending so it shows without a frame of delay.
      if (boundary) begin
        if (bus.load) begin
          display <= bus.d;
          flag    <= 1'b0;
        end else if (flag) begin
          display <= pending;
          flag    <= 1'b0;
        end
      end else if (bus.load) begin
        pending <= bus.d;
        flag    <= 1'b1;
      end

      an_q  <= (ACTIVE_LOW != 0) ? ~an_on : an_on;
      seg_q <= blank ? SEG_OFF : ((ACTIVE_LOW != 0) ? ~seg_on : seg_on);
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.dp         = (ACTIVE_LOW != 0);
  assign bus.frame_done = boundary;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: DIGITS=8, REFRESH_DIV=4, active-low.
// Each frame's expected display value is queued when loads are driven and popped when the frame is scanned.
module tb_seven_seg_scan_driver;

  localparam int DIGITS      = 8;
  localparam int REFRESH_DIV = 4;
  localparam int FRAME       = DIGITS * REFRESH_DIV;

  logic clk = 1'b0;
  logic clr;

  seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seven_seg_scan_driver #(
    .DIGITS     (DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .ACTIVE_LOW (1)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errs    = 0;
  logic [31:0] exp_q[$];

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] exp_seg(input logic [31:0] v, input int k);
    logic [31:0] s;
    s = v >> (4 * k);
`ifdef SEVEN_SEG_BLANK_LEADING_ZEROS_EN
    if (k != 0 && s == 32'h0) return 7'h7F;
`endif
    return ~hex_tab[s[3:0]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_an", {24'h0, bus.an}, 32'h0000_00FF);
    chk("rst_seg", {25'h0, bus.seg}, 32'h0000_007F);
    chk("rst_dp", {31'h0, bus.dp}, 32'h1);
    chk("rst_fd", {31'h0, bus.frame_done}, 32'h0);
  endtask

  // Window j is the j-th observed cycle of a frame; digit j/4 is lit, frame_done marks the boundary cycle.
  task automatic check_window(input int j, input logic [31:0] v);
    int         k;
    logic [7:0] ea;
    logic [6:0] es;
    k  = j / REFRESH_DIV;
    ea = ~(8'd1 << k);
    es = exp_seg(v, k);
    chk($sformatf("an_w%0d", j), {24'h0, bus.an}, {24'h0, ea});
    chk($sformatf("seg_w%0d", j), {25'h0, bus.seg}, {25'h0, es});
    chk($sformatf("fd_w%0d", j), {31'h0, bus.frame_done}, {31'h0, (j == FRAME - 2)});
  endtask

  // Scan one full frame; a load driven in windows 0..FRAME-2 becomes the next frame's display.
  task automatic run_frame(input int la, input logic [31:0] va,
                           input int lb, input logic [31:0] vb);
    logic [31:0] v;
    logic [31:0] nxt;
    if (exp_q.size() == 0) begin
      errs++;
      $display("FAIL exp_q: observed empty expected entry");
      v = 32'h0;
    end else begin
      v = exp_q.pop_front();
    end
    nxt = v;
    for (int j = 0; j < FRAME; j++) begin
      tick();
      check_window(j, v);
      if (j == la) begin
        bus.load = 1'b1;
        bus.d    = va;
        nxt      = va;
      end else if (j == lb) begin
        bus.load = 1'b1;
        bus.d    = vb;
        nxt      = vb;
      end else begin
        bus.load = 1'b0;
        bus.d    = $urandom;
      end
    end
    exp_q.push_back(nxt);
  endtask

  initial begin
    logic [31:0] v;
    int          rj;
    logic [31:0] rv;

    clr      = 1'b1;
    bus.load = 1'b0;
    bus.d    = 32'h0;
    tick();
    tick();
    check_reset_outputs();
    clr = 1'b0;
    exp_q.push_back(32'h0);

    // Idle: zeros across two frames.
    run_frame(-1, 32'h0, -1, 32'h0);
    run_frame(-1, 32'h0, -1, 32'h0);

    // Mid-frame load is held until the next boundary.
    run_frame(12, 32'h1234_5678, -1, 32'h0);
    run_frame(-1, 32'h0, -1, 32'h0);

    // Load coinciding with frame_done is committed directly.
    run_frame(FRAME - 2, 32'hDEAD_BEEF, -1, 32'h0);
    run_frame(-1, 32'h0, -1, 32'h0);

    // Last load in a frame wins.
    run_frame(5, 32'h0000_0001, 10, 32'h0000_0002);
    run_frame(-1, 32'h0, -1, 32'h0);

    // Value with leading zeros (blanked when the option is built in).
    run_frame(3, 32'h0000_00A0, -1, 32'h0);
    run_frame(-1, 32'h0, -1, 32'h0);

    rj = $urandom_range(0, FRAME - 2);
    rv = $urandom;
    run_frame(rj, rv, -1, 32'h0);
    run_frame(-1, 32'h0, -1, 32'h0);

    // Reset while digit 5 is lit with a pending load; a load during clr is ignored.
    v = exp_q.pop_front();
    for (int j = 0; j <= 20; j++) begin
      tick();
      check_window(j, v);
      if (j == 18) begin
        bus.load = 1'b1;
        bus.d    = 32'hCAFE_F00D;
      end else begin
        bus.load = 1'b0;
      end
    end
    clr      = 1'b1;
    bus.load = 1'b1;
    bus.d    = 32'h8765_4321;
    tick();
    check_reset_outputs();
    clr      = 1'b0;
    bus.load = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    run_frame(-1, 32'h0, -1, 32'h0);
    run_frame(-1, 32'h0, -1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
